// File: rtl/ahb_decoder_pkg.sv
// ahb_decoder_pkg: shared AHB transfer/response encodings and default-slave states
package ahb_decoder_pkg;
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;
   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_t;
   typedef enum logic [1:0] {
      DS_OK   = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;
   function automatic logic is_active(logic [1:0] htrans);
      return htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ;
   endfunction
endpackage

// File: rtl/ahb_decoder_if.sv
// ahb_decoder_if: muxed master request, per-slave selects/responses and muxed response
interface ahb_decoder_if #(parameter int NUM_SLVS = 4);
   logic [31:0]            haddr;
   logic [1:0]             htrans;
   logic [NUM_SLVS-1:0]    hsels;
   logic [NUM_SLVS-1:0]    hreadyouts;
   logic [2*NUM_SLVS-1:0]  hresps;
   logic [32*NUM_SLVS-1:0] hrdatas;
   logic                   hready;
   logic [1:0]             hresp;
   logic [31:0]            hrdata;
   modport slave(input haddr, htrans, hreadyouts, hresps, hrdatas, output hsels, hready, hresp, hrdata);
   modport master(output haddr, htrans, hreadyouts, hresps, hrdatas, input hsels, hready, hresp, hrdata);
endinterface

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped accesses, with error count and address log
module ahb_default_slave import ahb_decoder_pkg::*; #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic                 hready,
   input  logic                 dec_def,
   input  logic [1:0]           htrans,
   input  logic [31:0]          haddr,
   input  logic                 err_clr,
   output logic                 def_hready,
   output logic [1:0]           def_hresp,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [31:0]          err_addr
);
   ds_state_t state, state_nxt;
   logic err_go;
   always_ff @(posedge hclk or posedge hreset)
      if (hreset) begin
         state    <= DS_OK;
         err_cnt  <= '0;
         err_addr <= '0;
      end else begin
         state <= state_nxt;
         if (err_go) err_addr <= haddr;
         if (err_clr || (err_go && !(&err_cnt))) err_cnt <= err_clr ? ERR_CNT_W'(err_go) : err_cnt + 1'b1;
      end
   // err_go never depends on def_hready directly, so the hready feedback through the mux has no loop
   always_comb begin
      err_go    = state != DS_ERR1 && hready && dec_def && is_active(htrans);
      state_nxt = state == DS_ERR1 ? DS_ERR2 : err_go ? DS_ERR1 : DS_OK;
   end
   assign def_hready = state != DS_ERR1;
   assign def_hresp  = state == DS_OK ? HRESP_OKAY : HRESP_ERROR;
endmodule

// File: rtl/ahb_decoder.sv
// ahb_decoder: address decode, data-phase response mux and built-in default slave
module ahb_decoder import ahb_decoder_pkg::*; #(
   parameter int NUM_SLVS  = 4,
   parameter int DEC_LSB   = 28,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 hclk,
   input  logic                 hreset,
   ahb_decoder_if.slave         bus,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [31:0]          err_addr
);
   localparam int SW = 32 - DEC_LSB;
   logic [SW-1:0]       slot;
   logic [NUM_SLVS-1:0] sels;
   logic                dec_def, def_hready, hready_m;
   logic [1:0]          def_hresp, hresp_m;
   logic [31:0]         hrdata_m;
   logic [NUM_SLVS:0]   dsel;
   assign slot = bus.haddr[31:DEC_LSB];
   always_comb begin
      sels = '0;
      for (int k = 0; k < NUM_SLVS; k++) sels[k] = slot == SW'(k);
   end
   assign dec_def   = ~|sels;
   assign bus.hsels = sels;
   // dsel only moves on hready so wait states keep the same response source
   always_ff @(posedge hclk or posedge hreset)
      if (hreset) dsel <= {1'b1, {NUM_SLVS{1'b0}}};
      else if (bus.hready) dsel <= {dec_def, sels};
   always_comb begin
      hready_m = dsel[NUM_SLVS] & def_hready;
      hresp_m  = dsel[NUM_SLVS] ? def_hresp : HRESP_OKAY;
      hrdata_m = '0;
      for (int k = 0; k < NUM_SLVS; k++)
         if (dsel[k]) begin
            hready_m = bus.hreadyouts[k];
            hresp_m  = bus.hresps[2*k +: 2];
            hrdata_m = bus.hrdatas[32*k +: 32];
         end
   end
   assign bus.hready = hready_m;
   assign bus.hresp  = hresp_m;
   assign bus.hrdata = hrdata_m;
   ahb_default_slave #(.ERR_CNT_W(ERR_CNT_W)) u_def (
      .hclk       (hclk),
      .hreset     (hreset),
      .hready     (bus.hready),
      .dec_def    (dec_def),
      .htrans     (bus.htrans),
      .haddr      (bus.haddr),
      .err_clr    (err_clr),
      .def_hready (def_hready),
      .def_hresp  (def_hresp),
      .err_cnt    (err_cnt),
      .err_addr   (err_addr)
   );
endmodule

// File: tb/tb_ahb_decoder.sv
// tb_ahb_decoder: vector table, hand-written corner sequences and a randomized run against a transfer-level model
module tb_ahb_decoder;
   localparam int NS = 4;
   typedef struct {
      logic [31:0] a;
      logic [1:0]  t;
      logic [3:0]  rdy;
      logic        clr;
      logic [3:0]  sels;
      logic        rd;
      logic [1:0]  rs;
      logic [31:0] d;
      logic [7:0]  c;
      logic [31:0] ea;
   } vec_t;
   logic hclk = 1'b0, hreset = 1'b0, err_clr = 1'b0;
   logic [7:0]  err_cnt;
   logic [31:0] err_addr;
   int total = 0, bad = 0;
   int m_own, m_rem, m_cnt, n;
   logic [31:0] m_addr, ra;
   logic [1:0]  rt;
   logic [3:0]  rr;
   vec_t tbl[14];
   ahb_decoder_if #(.NUM_SLVS(NS)) bus ();
   ahb_decoder #(.NUM_SLVS(NS), .DEC_LSB(28), .ERR_CNT_W(8)) dut (
      .hclk(hclk), .hreset(hreset), .bus(bus), .err_clr(err_clr), .err_cnt(err_cnt), .err_addr(err_addr)
   );
   always #5 hclk = ~hclk;
   function automatic logic [78:0] dut_vec();
      return {bus.hsels, bus.hready, bus.hresp, bus.hrdata, err_cnt, err_addr};
   endfunction
   // model: m_own = data-phase owner (-1 = default slave), m_rem = ERROR cycles still to show
   function automatic logic m_ready();
      return m_own >= 0 ? bus.hreadyouts[m_own] : m_rem != 2;
   endfunction
   function automatic logic [78:0] model_vec();
      int sl = int'(bus.haddr[31:28]);
      logic [3:0] es = sl < NS ? 4'(1 << sl) : 4'b0;
      logic [1:0] er = m_own >= 0 ? bus.hresps[2*m_own +: 2] : (m_rem != 0 ? 2'b01 : 2'b00);
      logic [31:0] ed = m_own >= 0 ? bus.hrdatas[32*m_own +: 32] : 32'h0;
      return {es, m_ready(), er, ed, m_cnt[7:0], m_addr};
   endfunction
   task automatic m_reset();
      m_own = -1; m_rem = 0; m_cnt = 0; m_addr = '0;
   endtask
   task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got sels=%b rdy=%b resp=%b data=%h cnt=%h eaddr=%h, want sels=%b rdy=%b resp=%b data=%h cnt=%h eaddr=%h",
                  name, act[78:75], act[74], act[73:72], act[71:40], act[39:32], act[31:0],
                  exp[78:75], exp[74], exp[73:72], exp[71:40], exp[39:32], exp[31:0]);
      end
   endtask
   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask
   task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [3:0] rdy, input logic clr);
      bus.haddr = a; bus.htrans = t; bus.hreadyouts = rdy; err_clr = clr;
      #3;
   endtask
   task automatic adv();
      int sl = int'(bus.haddr[31:28]);
      int sel = sl < NS ? sl : -1;
      logic r = m_ready();
      logic e = r && sel < 0 && bus.htrans inside {2'b10, 2'b11};
      if (r) m_own = sel;
      m_rem = e ? 2 : (m_rem > 0 ? m_rem - 1 : 0);
      if (e) m_addr = bus.haddr;
      m_cnt = err_clr ? int'(e) : (e && m_cnt < 255 ? m_cnt + 1 : m_cnt);
      @(posedge hclk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, bad=%0d", bad);
      $fatal(1, "timeout");
   end
   initial begin
      bus.haddr = 32'hF000_0000; bus.htrans = 2'b00; bus.hreadyouts = 4'hF;
      bus.hresps = 8'b01_00_00_00;
      bus.hrdatas = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
      m_reset();
      #2 hreset = 1'b1;
      #1 chk("reset", dut_vec(), {4'b0000, 1'b1, 2'b00, 32'h0, 8'h00, 32'h0});
      @(posedge hclk);
      @(posedge hclk);
      #1 hreset = 1'b0;
      tbl[0]  = '{32'h2000_0010, 2'b10, 4'hF, 1'b0, 4'b0100, 1'b1, 2'b00, 32'h0,         8'd0, 32'h0};
      tbl[1]  = '{32'h0000_0000, 2'b00, 4'hB, 1'b0, 4'b0001, 1'b0, 2'b00, 32'hCAFE_0002, 8'd0, 32'h0};
      tbl[2]  = '{32'h0000_0000, 2'b00, 4'hB, 1'b0, 4'b0001, 1'b0, 2'b00, 32'hCAFE_0002, 8'd0, 32'h0};
      tbl[3]  = '{32'h0000_0000, 2'b00, 4'hF, 1'b0, 4'b0001, 1'b1, 2'b00, 32'hCAFE_0002, 8'd0, 32'h0};
      tbl[4]  = '{32'h7000_0004, 2'b10, 4'hF, 1'b0, 4'b0000, 1'b1, 2'b00, 32'hCAFE_0000, 8'd0, 32'h0};
      tbl[5]  = '{32'h7000_0008, 2'b11, 4'hF, 1'b0, 4'b0000, 1'b0, 2'b01, 32'h0,         8'd1, 32'h7000_0004};
      tbl[6]  = '{32'h7000_0008, 2'b11, 4'hF, 1'b0, 4'b0000, 1'b1, 2'b01, 32'h0,         8'd1, 32'h7000_0004};
      tbl[7]  = '{32'h9000_0000, 2'b00, 4'hF, 1'b0, 4'b0000, 1'b0, 2'b01, 32'h0,         8'd2, 32'h7000_0008};
      tbl[8]  = '{32'h9000_0000, 2'b00, 4'hF, 1'b0, 4'b0000, 1'b1, 2'b01, 32'h0,         8'd2, 32'h7000_0008};
      tbl[9]  = '{32'h9000_0000, 2'b01, 4'hF, 1'b0, 4'b0000, 1'b1, 2'b00, 32'h0,         8'd2, 32'h7000_0008};
      tbl[10] = '{32'h3000_0000, 2'b00, 4'hF, 1'b0, 4'b1000, 1'b1, 2'b00, 32'h0,         8'd2, 32'h7000_0008};
      tbl[11] = '{32'h0000_0000, 2'b00, 4'hF, 1'b0, 4'b0001, 1'b1, 2'b01, 32'hCAFE_0003, 8'd2, 32'h7000_0008};
      tbl[12] = '{32'h0000_0000, 2'b00, 4'hF, 1'b1, 4'b0001, 1'b1, 2'b00, 32'hCAFE_0000, 8'd2, 32'h7000_0008};
      tbl[13] = '{32'h0000_0000, 2'b00, 4'hF, 1'b0, 4'b0001, 1'b1, 2'b00, 32'hCAFE_0000, 8'd0, 32'h7000_0008};
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].a, tbl[i].t, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("vec%0d", i), dut_vec(),
             {tbl[i].sels, tbl[i].rd, tbl[i].rs, tbl[i].d, tbl[i].c, tbl[i].ea});
         adv();
      end
      n = 0;
      for (int k = 0; k < 1000 && n < 260; k++) begin
         drive(32'hF000_0000 | 32'(k), 2'b10, 4'hF, 1'b0);
         if (m_ready()) n++;
         adv();
      end
      chk_int("sat_errors_issued", n, 260);
      drive(32'hF000_0000, 2'b00, 4'hF, 1'b0); adv();
      drive(32'hF000_0000, 2'b00, 4'hF, 1'b0); adv();
      drive(32'hF000_0000, 2'b00, 4'hF, 1'b0);
      chk_int("sat_cnt", err_cnt, 255);
      drive(32'hF000_0000, 2'b10, 4'hF, 1'b1); adv();
      drive(32'hF000_0000, 2'b00, 4'hF, 1'b0);
      chk_int("clr_with_err", err_cnt, 1);
      adv();
      drive(32'hF000_0000, 2'b00, 4'hF, 1'b1); adv();
      drive(32'hF000_0000, 2'b00, 4'hF, 1'b0);
      chk_int("clr_alone", err_cnt, 0);
      adv();
      drive(32'hA000_0000, 2'b10, 4'hF, 1'b0); adv();
      drive(32'hA000_0000, 2'b00, 4'hF, 1'b0);
      chk_int("err1_wait", bus.hready, 0);
      hreset = 1'b1;
      m_reset();
      #1 chk("reset_mid_err", dut_vec(), {4'b0000, 1'b1, 2'b00, 32'h0, 8'h00, 32'h0});
      @(posedge hclk);
      #1 hreset = 1'b0;
      for (int k = 0; k < 600; k++) begin
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra[31:28] = 4'($urandom_range(0, NS - 1));
         rt = 2'($urandom);
         for (int j = 0; j < NS; j++) rr[j] = $urandom_range(0, 3) != 0;
         bus.hresps = 8'($urandom) & 8'h55;
         bus.hrdatas = {$urandom, $urandom, $urandom, $urandom};
         drive(ra, rt, rr, $urandom_range(0, 15) == 0);
         chk($sformatf("rnd%0d", k), dut_vec(), model_vec());
         adv();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
